// File: rtl/sram1p_port_ctrl_pkg.sv
// Shared constants, grant encoding and arbitration helper for the sram1p port controller.
package sram1p_port_ctrl_pkg;

    localparam int unsigned WORD_SIZE_DEF = 8;
    localparam int unsigned ADDR_SIZE_DEF = 4;
    localparam int unsigned RSP_DEPTH     = 2;
    localparam int unsigned CREDIT_LIMIT  = RSP_DEPTH;
    localparam int unsigned OCC_W         = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W         = $clog2(RSP_DEPTH);
    localparam int unsigned CRED_W        = OCC_W + 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_e;

    // Fair single-grant choice; ties go to whichever side did not win last time.
    function automatic grant_e arbitrate(input logic wr_pend, input logic rd_pend,
                                         input logic last_grant_wr);
        grant_e g;
        g = GNT_NONE;
        if (wr_pend && rd_pend) g = last_grant_wr ? GNT_RD : GNT_WR;
        else if (wr_pend)       g = GNT_WR;
        else if (rd_pend)       g = GNT_RD;
        return g;
    endfunction

endpackage

// File: rtl/sram1p_port_ctrl_if.sv
// Requester-side write/read/response handshake bundle for the sram1p port controller.
interface sram1p_port_ctrl_if #(
    parameter int unsigned WORD_SIZE = 8,
    parameter int unsigned ADDR_SIZE = 4
);
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;

    modport master (
        output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        input  wr_ready, rd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready,
        output wr_ready, rd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram1p_rsp_fifo.sv
// Two-entry ordered response buffer that captures SRAM read data for the consumer.
module sram1p_rsp_fifo
    import sram1p_port_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] push_data,
    input  logic                 pop,
    output logic [WORD_SIZE-1:0] pop_data,
    output logic [OCC_W-1:0]     occ
);

    logic [WORD_SIZE-1:0] mem [RSP_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 pop_ok;

    assign pop_ok   = pop && (occ != '0);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            // The credit check upstream must make a push into a full buffer impossible.
            if (push) assert (occ != OCC_W'(RSP_DEPTH))
                else $error("sram1p_rsp_fifo: push into full response buffer");
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop_ok})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/sram1p_port_ctrl.sv
// Arbitrates write and read request streams onto one sram1p port and returns read data in order.
module sram1p_port_ctrl
    import sram1p_port_ctrl_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram1p_port_ctrl_if.slave    bus,
    output logic                 mem_write_enable,
    output logic                 mem_read_enable,
    output logic [ADDR_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_write_data,
    input  logic [WORD_SIZE-1:0] mem_read_data
);

    logic              run;
    logic              inflight;
    logic              last_grant_wr;
    logic [OCC_W-1:0]  occ;
    logic              pop;
    logic [CRED_W-1:0] committed;
    logic              wr_pend;
    logic              rd_pend;
    grant_e            grant;
    logic              grant_wr;
    logic              grant_rd;

    // Slots already claimed in the response buffer, net of a pop happening this cycle.
    assign pop       = bus.rsp_valid && bus.rsp_ready;
    assign committed = CRED_W'(occ) + CRED_W'(inflight) - CRED_W'(pop);

    always_comb begin
        wr_pend  = run && bus.wr_valid;
        rd_pend  = run && bus.rd_valid && (committed < CRED_W'(CREDIT_LIMIT));
        grant    = arbitrate(wr_pend, rd_pend, last_grant_wr);
        grant_wr = (grant == GNT_WR);
        grant_rd = (grant == GNT_RD);
    end

    assign bus.wr_ready     = grant_wr;
    assign bus.rd_ready     = grant_rd;
    assign mem_write_enable = grant_wr;
    assign mem_read_enable  = grant_rd;
    assign mem_address      = grant_rd ? bus.rd_addr : bus.wr_addr;
    assign mem_write_data   = bus.wr_data;
    assign bus.rsp_valid    = (occ != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run           <= 1'b0;
            inflight      <= 1'b0;
            last_grant_wr <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= grant_rd;
            if (grant_wr || grant_rd) last_grant_wr <= grant_wr;
        end
    end

    sram1p_rsp_fifo #(.WORD_SIZE(WORD_SIZE)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .push_data (mem_read_data),
        .pop       (pop),
        .pop_data  (bus.rsp_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_sram1p_port_ctrl.sv
// Directed bench for sram1p_port_ctrl with an SRAM model and an in-order response scoreboard.
module tb_sram1p_port_ctrl;

    localparam int unsigned WORD_SIZE = 8;
    localparam int unsigned ADDR_SIZE = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 mem_write_enable;
    logic                 mem_read_enable;
    logic [ADDR_SIZE-1:0] mem_address;
    logic [WORD_SIZE-1:0] mem_write_data;
    logic [WORD_SIZE-1:0] mem_read_data;

    int checks = 0;
    int errors = 0;

    logic [WORD_SIZE-1:0] sram  [16];
    logic [WORD_SIZE-1:0] model [16];
    logic [WORD_SIZE-1:0] exp_q [$];

    sram1p_port_ctrl_if #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) bus ();

    sram1p_port_ctrl #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus.slave),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sram1p: write has priority, read data registered, contents survive reset.
    always @(posedge clk) begin
        if (mem_write_enable)     sram[mem_address] <= mem_write_data;
        else if (mem_read_enable) mem_read_data     <= sram[mem_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expectations taken from the bench's own memory model at read acceptance.
    always @(negedge clk) begin
        if (rst_n) begin
            check("mem_enable_exclusive", 32'(mem_write_enable && mem_read_enable), 32'd0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
                else                   check("rsp_data_order", 32'(bus.rsp_data), 32'(exp_q.pop_front()));
            end
            if (bus.rd_valid && bus.rd_ready) exp_q.push_back(model[bus.rd_addr]);
            if (bus.wr_valid && bus.wr_ready) model[bus.wr_addr] = bus.wr_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input logic [WORD_SIZE-1:0] exp);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
        check(tag, 32'(bus.rsp_data), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int first;
        int last;
        int nrsp;

        for (int i = 0; i < 16; i++) begin
            sram[i]  = '0;
            model[i] = '0;
        end
        rst_n         = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 4'd3;
        bus.wr_data   = 8'hA5;
        bus.rd_valid  = 1'b0;
        bus.rd_addr   = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        check("rst_mem_re", 32'(mem_read_enable), 32'd0);

        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd0);

        // First write A5 -> addr 3, then read it back
        step();
        @(negedge clk);
        check("wr_grant", 32'(bus.wr_ready), 32'd1);
        check("wr_mem_we", 32'(mem_write_enable), 32'd1);
        check("wr_mem_addr", 32'(mem_address), 32'd3);
        check("wr_mem_data", 32'(mem_write_data), 32'hA5);
        step();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 4'd3;
        @(negedge clk);
        check("rd_grant", 32'(bus.rd_ready), 32'd1);
        check("rd_mem_re", 32'(mem_read_enable), 32'd1);
        step();
        bus.rd_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        @(negedge clk);
        check("lat_n2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("lat_n2_rsp_data", 32'(bus.rsp_data), 32'hA5);

        // Read-after-write in consecutive cycles
        step();
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd5;
        bus.wr_data  = 8'h11;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 4'd5;
        step();
        bus.rd_valid = 1'b0;
        wait_rsp("raw_rsp", 8'h11);

        // Contention: both valid for 6 cycles
        repeat (3) step();
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 4'd8;
            bus.wr_data  = 8'(8'h20 + i);
            bus.rd_valid = 1'b1;
            bus.rd_addr  = 4'd5;
            @(negedge clk);
            check("cont_wr_ready", 32'(bus.wr_ready), 32'((i % 2) == 0));
            check("cont_rd_ready", 32'(bus.rd_ready), 32'((i % 2) == 1));
            step();
        end
        bus.wr_valid = 1'b0;
        bus.rd_valid = 1'b0;

        // Fill addr 0..3 with 0x10..0x13
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 4'(i);
            bus.wr_data  = 8'(8'h10 + i);
            step();
        end
        bus.wr_valid = 1'b0;
        repeat (4) step();

        // Backpressure: only two reads accepted while rsp_ready is low
        bus.rsp_ready = 1'b0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 4'd0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rd_ready) acc++;
            step();
            bus.rd_addr = 4'(acc);
        end
        check("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        check("bp_rd_ready_low", 32'(bus.rd_ready), 32'd0);
        check("bp_head_data", 32'(bus.rsp_data), 32'h10);
        step();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 20 && acc < 4; i++) begin
            @(negedge clk);
            if (bus.rd_ready) acc++;
            step();
            if (acc >= 4) bus.rd_valid = 1'b0;
            else          bus.rd_addr  = 4'(acc);
        end
        bus.rd_valid = 1'b0;
        check("bp_all_accepted", 32'(acc), 32'd4);
        repeat (5) step();
        check("bp_drained", 32'(exp_q.size()), 32'd0);

        // Streaming: 8 back-to-back reads
        first = -1;
        last  = -1;
        nrsp  = 0;
        for (int i = 0; i < 12; i++) begin
            bus.rd_valid = (i < 8);
            bus.rd_addr  = 4'(i % 4);
            @(negedge clk);
            if (i < 8) check("stream_rd_ready", 32'(bus.rd_ready), 32'd1);
            if (bus.rsp_valid) begin
                if (first < 0) first = i;
                last = i;
                nrsp++;
            end
            step();
        end
        bus.rd_valid = 1'b0;
        check("stream_rsp_count", 32'(nrsp), 32'd8);
        check("stream_rsp_span", 32'(last - first), 32'd7);

        // Reset with occ=1 and a read in flight
        repeat (3) step();
        bus.rsp_ready = 1'b0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr   = 4'd0;
        step();
        bus.rd_addr = 4'd1;
        step();
        bus.rd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        exp_q.delete();
        step();
        rst_n         = 1'b1;
        bus.rsp_ready = 1'b1;
        nrsp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) nrsp++;
            step();
        end
        check("no_stale_rsp", 32'(nrsp), 32'd0);

        // SRAM contents survive controller reset
        bus.rd_valid = 1'b1;
        bus.rd_addr  = 4'd5;
        @(negedge clk);
        check("post_rst_rd_grant", 32'(bus.rd_ready), 32'd1);
        step();
        bus.rd_valid = 1'b0;
        wait_rsp("post_rst_rsp", 8'h11);
        repeat (3) step();
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram1p_port_ctrl.md
# sram1p_port_ctrl

Requester-side controller for the single-port SRAM (`sram1p`) used throughout the compressor datapath. It accepts independent write and read request streams (valid/ready), arbitrates them fairly onto the one SRAM port, and tracks the SRAM's one-cycle registered read latency. Read data is returned through a credit-protected 2-entry response buffer, so downstream backpressure never drops data. It sits between hash/history-buffer logic and each `sram1p` instance.

## Interface
- WORD_SIZE, 8, data width; must equal the attached SRAM's WORD_SIZE
- ADDR_SIZE, 4, address width; must equal the attached SRAM's ADDR_SIZE
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_valid  in  1  write request present
- wr_ready  out  1  write request granted this cycle
- wr_addr  in  ADDR_SIZE  write address
- wr_data  in  WORD_SIZE  write data
- rd_valid  in  1  read request present
- rd_ready  out  1  read request granted this cycle
- rd_addr  in  ADDR_SIZE  read address
- rsp_valid  out  1  read response available
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  WORD_SIZE  read response data, in request order
- mem_write_enable  out  1  to SRAM write_enable
- mem_read_enable  out  1  to SRAM read_enable
- mem_address  out  ADDR_SIZE  to SRAM address
- mem_write_data  out  WORD_SIZE  to SRAM write_data
- mem_read_data  in  WORD_SIZE  from SRAM read_data

## Operation
- Registered `run` flag: cleared by reset, set on the first clk edge after rst_n deasserts. While `run`=0: wr_ready, rd_ready, mem_write_enable and mem_read_enable are 0.
- Read eligibility: rd_valid && (occ + inflight − pop) < 2.
  - occ: response buffer occupancy, 0..2.
  - inflight: 1 if a read was issued last cycle.
  - pop: rsp_valid && rsp_ready.
- Arbitration, at most one grant per cycle:
  - Write only pending → grant write.
  - Eligible read only pending → grant read.
  - Both pending → grant the opposite of `last_grant_wr`. That register resets to 0, so write wins the first tie.
  - `last_grant_wr` updates only on a grant.
- wr_ready = grant_wr. rd_ready = grant_rd. Both are combinational; they may depend on the other channel's valid and on rsp_ready.
- Grant write: mem_write_enable=1, mem_address=wr_addr, mem_write_data=wr_data.
- Grant read: mem_read_enable=1, mem_address=rd_addr.
- Idle: both enables 0. Address and data are don't-care, but must be driven from the selected inputs, not X.
- Never assert mem_write_enable and mem_read_enable together. The SRAM gives write priority and would silently drop the read.
- The cycle after a read grant, mem_read_data is pushed into the response buffer, which is FIFO-ordered.
- rsp_valid = occ != 0. rsp_data = head entry.
- Push and pop in the same cycle: occ is unchanged and order is preserved.
- The credit rule guarantees a push never finds the buffer full. Assert this in simulation.
- Read-after-write to the same address in consecutive cycles returns the new data. The SRAM writes at edge N and reads at edge N+1; no forwarding is required.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, occ=0, inflight=0, last_grant_wr=0, run=0. All ready and enable outputs are 0 during and one cycle after reset.
- Read latency: rd_valid&&rd_ready in cycle N → rsp_valid in cycle N+2, provided the buffer was empty.
- Throughput: one read per cycle sustained while rsp_ready is held 1. One write per cycle when no reads are pending. Alternating 1:1 under contention.
- Reset mid-operation: any in-flight read is discarded, the buffer is emptied, and the SRAM contents are untouched. The consumer must drop outstanding expectations.
- With rsp_ready held 0, at most 2 reads are accepted. rd_ready then stays 0 until a pop occurs.

## Structure
- Shared header or package: localparam RSP_DEPTH=2, the credit-limit constant, and the `TD` delay macro already in util.vh.
- Sub-module `sram1p_rsp_fifo`: 2-entry synchronous FIFO with push/pop, occupancy output, and asynchronous active-low reset.
- Top level holds the arbiter, run flag, inflight register and output muxing.
- Bench instantiates `sram1p` with matching parameters.

## Test plan
- Reset release → ready outputs stay 0 for one cycle. Write 0xA5 to addr 3, then read addr 3 → rsp_data=0xA5 two cycles after the read grant.
- Back-to-back: write addr 5=0x11, then read addr 5 the very next cycle → returns 0x11.
- Contention: wr_valid and rd_valid held 1 for 6 cycles → grants go W,R,W,R,W,R. mem_write_enable and mem_read_enable never both high.
- Backpressure: rsp_ready=0, issue 4 reads of addr 0..3 holding 0x10..0x13 → only 2 accepted. Raise rsp_ready → receive 0x10, 0x11, then remaining reads complete in order.
- Streaming: rsp_ready=1, 8 consecutive reads → rd_ready high every cycle and 8 responses on 8 consecutive cycles.
- Reset asserted with a read in flight and occ=1 → rsp_valid drops immediately. After release, no stale response appears.
